// File: rtl/sprite_blitter.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_blitter
//  Purpose  : Copies a sprite from a combinational sprite ROM into a frame
//             buffer. Pixels are walked in row-major order. Transparent
//             pixels and pixels outside the screen are dropped, and every
//             other pixel is written through a valid/ready write port.
//  Ports    : clk, rst          - clock, asynchronous active-high reset
//             start             - blit request (sampled only when idle)
//             x_pos, y_pos      - sprite top-left screen position
//             flip_h            - horizontal mirror
//             busy, done        - status / one-cycle completion pulse
//             pixel             - sprite ROM index
//             width, height     - ROM dimensions, 0-indexed
//             color             - ROM colour for the current pixel
//             fb_addr, fb_data  - frame buffer write address / data
//             fb_we, fb_ready   - frame buffer write handshake
//  Revision : 1.0 - initial release
// ============================================================================
module sprite_blitter #(
    parameter int          SCREEN_W    = 320,
    parameter int          SCREEN_H    = 240,
    parameter logic [15:0] TRANSPARENT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [8:0]  x_pos,
    input  logic [8:0]  y_pos,
    input  logic        flip_h,
    output logic        busy,
    output logic        done,
    output logic [16:0] pixel,
    input  logic [8:0]  width,
    input  logic [8:0]  height,
    input  logic [15:0] color,
    output logic [16:0] fb_addr,
    output logic [15:0] fb_data,
    output logic        fb_we,
    input  logic        fb_ready
);

    localparam logic [9:0]  c_screen_w10 = 10'(SCREEN_W);
    localparam logic [9:0]  c_screen_h10 = 10'(SCREEN_H);
    localparam logic [16:0] c_screen_w17 = 17'(SCREEN_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [8:0]  r_col;
    logic [8:0]  r_row;
    logic [16:0] r_row_base;
    logic [8:0]  r_wmax;
    logic [8:0]  r_hmax;
    logic [8:0]  r_x0;
    logic [8:0]  r_y0;
    logic        r_flip;

    logic [8:0]  w_col_src;
    logic [9:0]  w_sx;
    logic [9:0]  w_sy;
    logic        w_skip;
    logic        w_last_col;
    logic        w_last;
    logic        w_advance;
    logic        w_issue;
    logic [16:0] w_addr;

    // Mirroring only changes which ROM column is fetched; the screen column
    // (x0 + col) still advances left to right.
    assign w_col_src = r_flip ? (r_wmax - r_col) : r_col;
    assign pixel     = r_row_base + {8'd0, w_col_src};

    // Screen coordinates are one bit wider than the inputs so that a sprite
    // hanging off the right/bottom edge cannot wrap back onto the screen.
    assign w_sx   = {1'b0, r_x0} + {1'b0, r_col};
    assign w_sy   = {1'b0, r_y0} + {1'b0, r_row};
    assign w_skip = (color == TRANSPARENT) || (w_sx >= c_screen_w10) ||
                    (w_sy >= c_screen_h10);
    // Only evaluated for on-screen pixels, where sy*SCREEN_W+sx fits 17 bits.
    assign w_addr = ({7'd0, w_sy} * c_screen_w17) + {7'd0, w_sx};

    assign w_last_col = (r_col == r_wmax);
    assign w_last     = w_last_col && (r_row == r_hmax);

    assign busy = (r_state == S_LATCH) || (r_state == S_READ) ||
                  (r_state == S_WRITE);
    assign done = (r_state == S_DONE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; w_advance marks the cycle a pixel is finished.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_advance   = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LATCH;
                end
            end
            S_LATCH: begin
                w_state_nxt = S_READ;
            end
            S_READ: begin
                if (w_skip) begin
                    w_advance   = 1'b1;
                    w_state_nxt = w_last ? S_DONE : S_READ;
                end else begin
                    w_issue     = 1'b1;
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (fb_ready) begin
                    w_advance   = 1'b1;
                    w_state_nxt = w_last ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: latched sprite parameters, walk counters, write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col      <= 9'd0;
            r_row      <= 9'd0;
            r_row_base <= 17'd0;
            r_wmax     <= 9'd0;
            r_hmax     <= 9'd0;
            r_x0       <= 9'd0;
            r_y0       <= 9'd0;
            r_flip     <= 1'b0;
            fb_addr    <= 17'd0;
            fb_data    <= 16'd0;
            fb_we      <= 1'b0;
        end else begin
            if (r_state == S_LATCH) begin
                r_x0       <= x_pos;
                r_y0       <= y_pos;
                r_flip     <= flip_h;
                r_wmax     <= width;
                r_hmax     <= height;
                r_col      <= 9'd0;
                r_row      <= 9'd0;
                r_row_base <= 17'd0;
            end

            if (w_advance) begin
                if (w_last_col) begin
                    r_col      <= 9'd0;
                    r_row      <= r_row + 9'd1;
                    r_row_base <= r_row_base + {8'd0, r_wmax} + 17'd1;
                end else begin
                    r_col <= r_col + 9'd1;
                end
            end

            if (w_issue) begin
                fb_addr <= w_addr;
                fb_data <= color;
                fb_we   <= 1'b1;
            end else if ((r_state == S_WRITE) && fb_ready) begin
                fb_we <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_blitter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_blitter
//  Purpose  : Self-checking bench for sprite_blitter. A table of blit
//             scenarios is run; a reference model pushes expected frame
//             buffer writes to a queue that a monitor pops on each accepted
//             write. Reset-in-WRITE is exercised by a hand-written sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_blitter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [8:0]  x_pos;
    logic [8:0]  y_pos;
    logic        flip_h;
    logic        busy;
    logic        done;
    logic [16:0] pixel;
    logic [8:0]  width;
    logic [8:0]  height;
    logic [15:0] color;
    logic [16:0] fb_addr;
    logic [15:0] fb_data;
    logic        fb_we;
    logic        fb_ready;

    sprite_blitter dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .x_pos    (x_pos),
        .y_pos    (y_pos),
        .flip_h   (flip_h),
        .busy     (busy),
        .done     (done),
        .pixel    (pixel),
        .width    (width),
        .height   (height),
        .color    (color),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .fb_we    (fb_we),
        .fb_ready (fb_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational sprite ROM
    logic [15:0] rom_mem [0:1023];
    assign color = (pixel < 17'd1024) ? rom_mem[pixel[9:0]] : 16'hFFFF;

    localparam logic [15:0] c_a = 16'h1111;
    localparam logic [15:0] c_b = 16'h2222;
    localparam logic [15:0] c_c = 16'h3333;
    localparam logic [15:0] c_d = 16'h4444;

    typedef struct packed {
        logic [16:0] a;
        logic [15:0] d;
    } wr_t;

    typedef struct {
        int x;
        int y;
        int w;
        int h;
        bit flip;
        int stall;
        bit perturb;
        int exp_writes;
        int exp_cycles;
    } vec_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    int   n_cmp;
    int   n_bad;
    int   wr_cnt;
    int   done_cnt;
    vec_t vecs[7];

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted write must match the queue head.
    always @(negedge clk) begin
        if (!rst && done) done_cnt++;
        if (!rst && fb_we && fb_ready) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("fb_addr", int'(fb_addr), int'(mon_e.a));
                check("fb_data", int'(fb_data), int'(mon_e.d));
            end
        end
    end

    // Reference model: expected writes of one blit in row-major order.
    task automatic push_model(input vec_t v);
        wr_t t;
        int  sx, sy, idx;
        for (int r = 0; r <= v.h; r++) begin
            for (int c = 0; c <= v.w; c++) begin
                sx  = v.x + c;
                sy  = v.y + r;
                idx = r * (v.w + 1) + (v.flip ? (v.w - c) : c);
                if (rom_mem[idx] != 16'hFFFF && sx < 320 && sy < 240) begin
                    t.a = 17'(sy * 320 + sx);
                    t.d = rom_mem[idx];
                    exp_q.push_back(t);
                end
            end
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int          n;
        int          stall;
        logic [16:0] hold_a;
        logic [15:0] hold_d;
        push_model(v);
        wr_cnt   = 0;
        done_cnt = 0;
        hold_a   = '0;
        hold_d   = '0;
        @(posedge clk); #1;
        x_pos    = 9'(v.x);
        y_pos    = 9'(v.y);
        flip_h   = v.flip;
        width    = 9'(v.w);
        height   = 9'(v.h);
        fb_ready = 1'b1;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n     = 1;
        stall = v.stall;
        while (!done && n < 5000) begin
            if (n == 1) check($sformatf("v%0d_busy_latch", id), int'(busy), 1);
            if (stall > 0 && fb_we) begin
                if (stall == v.stall) begin
                    hold_a = fb_addr;
                    hold_d = fb_data;
                end else begin
                    check($sformatf("v%0d_stall_addr", id), int'(fb_addr), int'(hold_a));
                    check($sformatf("v%0d_stall_data", id), int'(fb_data), int'(hold_d));
                end
                fb_ready = 1'b0;
                stall--;
            end else begin
                fb_ready = 1'b1;
            end
            // Mid-blit start pulse and dimension change must have no effect.
            if (v.perturb && n == 3) begin
                start  = 1'b1;
                width  = 9'd0;
                height = 9'd0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        if (n >= 5000) check($sformatf("v%0d_timeout", id), 1, 0);
        check($sformatf("v%0d_cycles", id), n, v.exp_cycles);
        check($sformatf("v%0d_busy_in_done", id), int'(busy), 0);
        // start during the DONE cycle must be ignored
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check($sformatf("v%0d_done_pulse", id), int'(done), 0);
        check($sformatf("v%0d_busy_after", id), int'(busy), 0);
        @(posedge clk); #1;
        check($sformatf("v%0d_idle_after", id), int'(busy), 0);
        check($sformatf("v%0d_writes", id), wr_cnt, v.exp_writes);
        check($sformatf("v%0d_queue_left", id), exp_q.size(), 0);
        check($sformatf("v%0d_done_count", id), done_cnt, 1);
        exp_q.delete();
    endtask

    initial begin
        int n;
        n_cmp    = 0;
        n_bad    = 0;
        wr_cnt   = 0;
        done_cnt = 0;
        rst      = 1'b1;
        start    = 1'b0;
        x_pos    = '0;
        y_pos    = '0;
        flip_h   = 1'b0;
        width    = '0;
        height   = '0;
        fb_ready = 1'b1;

        for (int i = 0; i < 1024; i++)
            rom_mem[i] = (i >= 4 && (i % 7) == 5) ? 16'hFFFF : 16'(i);
        rom_mem[0] = c_a;
        rom_mem[1] = c_b;
        rom_mem[2] = c_c;
        rom_mem[3] = c_d;

        //          x    y    w   h  flip stall pert writes cycles
        vecs[0] = '{ 10,  20,  1,  1, 1'b0, 0, 1'b0,   4,   10};
        vecs[1] = '{ 10,  20,  1,  1, 1'b1, 0, 1'b0,   4,   10};
        vecs[2] = '{319, 239,  1,  1, 1'b0, 0, 1'b0,   1,    7};
        vecs[3] = '{ 10,  20,  1,  1, 1'b0, 5, 1'b0,   4,   15};
        vecs[4] = '{  5,   5,  0,  0, 1'b0, 0, 1'b0,   1,    4};
        vecs[5] = '{320,   0,  1,  1, 1'b0, 0, 1'b0,   0,    6};
        vecs[6] = '{  0,   0, 33, 29, 1'b0, 0, 1'b1, 875, 1897};

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",    int'(busy),    0);
        check("rst_done",    int'(done),    0);
        check("rst_fb_we",   int'(fb_we),   0);
        check("rst_pixel",   int'(pixel),   0);
        check("rst_fb_addr", int'(fb_addr), 0);
        check("rst_fb_data", int'(fb_data), 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Reset while a write is pending: the write must vanish immediately.
        done_cnt = 0;
        @(posedge clk); #1;
        x_pos    = 9'd10;
        y_pos    = 9'd20;
        flip_h   = 1'b0;
        width    = 9'd1;
        height   = 9'd1;
        fb_ready = 1'b0;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n     = 0;
        while (!fb_we && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("rstw_reached_write", int'(fb_we), 1);
        rst = 1'b1;
        #1;
        check("rstw_fb_we", int'(fb_we), 0);
        check("rstw_busy",  int'(busy),  0);
        check("rstw_pixel", int'(pixel), 0);
        @(posedge clk); @(posedge clk); #1;
        rst      = 1'b0;
        fb_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rstw_no_done", done_cnt, 0);
        check("rstw_no_busy", int'(busy), 0);
        exp_q.delete();
        run_vec(7, vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
